// File: rtl/dio_pkg.sv
// Shared definitions for the download router: FSM state encoding and the
// width helper used for channel tags.
package dio_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SKIP  = 3'd1,
        LOAD  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } dioState;

    // Width of a channel tag; a single channel still needs one bit.
    function automatic int chanWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dio_fifo.sv
// Synchronous FIFO with a combinational head view. Pointers carry one extra
// wrap bit so full and empty are distinguishable. Pushes into a full FIFO
// and pops from an empty one are ignored.
module dio_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wrPtr;
    logic [PW:0]  rdPtr;
    logic         doPush;
    logic         doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
    assign count  = wrPtr - rdPtr;
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdata  = mem[rdPtr[PW-1:0]];

    // Storage array; no reset so it maps onto distributed/block memory.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr[PW-1:0]] <= wdata;
        end
    end

    // Pointer advance; reset empties the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

endmodule

// File: rtl/dio_router.sv
// Download router: picks a target channel from the download index, buffers
// bytes (tagged with channel and rebased address) in a FIFO that drains over
// a ready/valid memory port, and reports completion, length and overflow.
module dio_router
    import dio_pkg::*;
#(
    parameter int                        CHANNELS = 4,
    parameter int                        IDXW     = 8,
    parameter int                        AW       = 27,
    parameter int                        DEPTH    = 8,
    parameter logic [IDXW*CHANNELS-1:0]  CH_LO    = {8'd3, 8'd2, 8'd1, 8'd0},
    parameter logic [IDXW*CHANNELS-1:0]  CH_HI    = {8'd3, 8'd2, 8'd1, 8'd1},
    parameter logic [AW*CHANNELS-1:0]    CH_BASE  = '0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              dioE,
    input  logic [IDXW-1:0]                   dioI,
    input  logic [AW-1:0]                     dioA,
    input  logic [7:0]                        dioD,
    input  logic                              dioW,
    output logic [CHANNELS-1:0]               chE,
    output logic                              memV,
    input  logic                              memR,
    output logic [AW-1:0]                     memA,
    output logic [7:0]                        memD,
    output logic [chanWidth(CHANNELS)-1:0]    memC,
    output logic [CHANNELS-1:0]               done,
    output logic [31:0]                       len,
    output logic                              ovf,
    input  logic                              ovfClr
);
    localparam int CW = chanWidth(CHANNELS);
    localparam int EW = CW + AW + 8;
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE_LEFT = 1;

    dioState             stateReg, stateNext;
    logic                dioEPrev;
    logic [CW-1:0]       chReg;
    logic [31:0]         cntReg;
    logic [31:0]         lenReg;
    logic                ovfReg;

    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] chSel;
    logic [AW-1:0]       baseArr [CHANNELS];
    logic                hitAny;
    logic [CW-1:0]       hitCh;
    logic [AW-1:0]       chBase;
    logic [AW-1:0]       pushAddr;

    logic                fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [PW:0]         fifoCount;
    logic [EW-1:0]       fifoHead;

    logic                dioRise, startLoad, dropByte, drainEnd;

    // Per-channel range compare, base extraction and one-hot select.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign hit[gi]     = (dioI >= CH_LO[gi*IDXW +: IDXW]) &&
                                 (dioI <= CH_HI[gi*IDXW +: IDXW]);
            assign baseArr[gi] = CH_BASE[gi*AW +: AW];
            assign chSel[gi]   = (chReg == CW'(gi));
        end
    endgenerate

    // Lowest matching channel wins; scan downward so the last hit is lowest.
    always_comb begin
        hitAny = 1'b0;
        hitCh  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hitAny = 1'b1;
                hitCh  = CW'(i);
            end
        end
    end

    // Base address of the latched channel.
    always_comb begin
        chBase = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chReg == CW'(i)) chBase = baseArr[i];
        end
    end

    assign dioRise   = dioE && !dioEPrev;
    assign startLoad = (stateReg == IDLE) && dioRise && hitAny;
    assign pushAddr  = dioA + chBase;
    assign fifoPush  = (stateReg == LOAD) && dioW && !fifoFull;
    assign fifoPop   = memR;
    assign dropByte  = dioW && (((stateReg == LOAD) && fifoFull) ||
                                 (stateReg == DRAIN) || (stateReg == DONE));
    // Leave DRAIN in the cycle the last entry is accepted, so done follows it directly.
    assign drainEnd  = fifoEmpty || ((fifoCount == ONE_LEFT) && memR);

    dio_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifoPush),
        .pop   (fifoPop),
        .wdata ({chReg, pushAddr, dioD}),
        .rdata (fifoHead),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stateReg <= IDLE;
        else        stateReg <= stateNext;
    end

    // Next-state logic.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (dioRise) stateNext = hitAny ? LOAD : SKIP;
            SKIP:    if (!dioE) stateNext = IDLE;
            LOAD:    if (!dioE) stateNext = DRAIN;
            DRAIN:   if (drainEnd) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Load bookkeeping: edge detect, channel latch, byte count, length, overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dioEPrev <= 1'b0;
            chReg    <= '0;
            cntReg   <= '0;
            lenReg   <= '0;
            ovfReg   <= 1'b0;
        end else begin
            dioEPrev <= dioE;
            if (startLoad) begin
                chReg  <= hitCh;
                cntReg <= '0;
            end else if (fifoPush) begin
                cntReg <= cntReg + 32'd1;
            end
            if ((stateReg == DRAIN) && drainEnd) lenReg <= cntReg;
            if (dropByte)    ovfReg <= 1'b1;
            else if (ovfClr) ovfReg <= 1'b0;
        end
    end

    // Outputs: channel enable, done pulse and the FIFO head on the memory port.
    always_comb begin
        chE  = ((stateReg == LOAD) || (stateReg == DRAIN)) ? chSel : '0;
        done = (stateReg == DONE) ? chSel : '0;
        memV = !fifoEmpty;
        {memC, memA, memD} = fifoEmpty ? '0 : fifoHead;
        len  = lenReg;
        ovf  = ovfReg;
    end

endmodule

// File: tb/tb_dio_router.sv
// Self-checking bench for dio_router: a queue-based reference model checked
// every cycle, a table of download scenarios, and hand-written corner cases.
module tb_dio_router;
    localparam int CH    = 4;
    localparam int IW    = 8;
    localparam int AW    = 27;
    localparam int DEPTH = 8;
    localparam int P_IDLE = 0, P_SKIP = 1, P_LOAD = 2, P_DRAIN = 3, P_DONE = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          dioE = 1'b0, dioW = 1'b0, memR = 1'b0, ovfClr = 1'b0;
    logic [IW-1:0] dioI = '0;
    logic [AW-1:0] dioA = '0;
    logic [7:0]    dioD = '0;
    logic [CH-1:0] chE, done;
    logic          memV, ovf;
    logic [AW-1:0] memA;
    logic [7:0]    memD;
    logic [1:0]    memC;
    logic [31:0]   len;

    dio_router #(
        .CHANNELS (CH),
        .IDXW     (IW),
        .AW       (AW),
        .DEPTH    (DEPTH),
        .CH_LO    ({8'd3, 8'd2, 8'd1, 8'd0}),
        .CH_HI    ({8'd3, 8'd2, 8'd1, 8'd1}),
        .CH_BASE  ({27'h0400000, 27'h0300000, 27'h0200000, 27'h0100000})
    ) dut (
        .clock (clock), .reset (reset),
        .dioE (dioE), .dioI (dioI), .dioA (dioA), .dioD (dioD), .dioW (dioW),
        .chE (chE), .memV (memV), .memR (memR), .memA (memA), .memD (memD),
        .memC (memC), .done (done), .len (len), .ovf (ovf), .ovfClr (ovfClr)
    );

    always #5 clock = ~clock;

    int nCmp = 0;
    int nErr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: channel map, pending-write queue and load bookkeeping.
    typedef struct { logic [1:0] c; logic [AW-1:0] a; logic [7:0] d; } ent_t;
    int            lo [CH] = '{0, 1, 2, 3};
    int            hi [CH] = '{1, 1, 2, 3};
    logic [AW-1:0] base [CH] = '{27'h0100000, 27'h0200000, 27'h0300000, 27'h0400000};
    ent_t          mQ [$];
    int            mPh, mCh;
    logic          mPrevE, mOvf;
    logic [31:0]   mCnt, mLen;
    int            doneSeen;
    logic [CH-1:0] doneOr;

    function automatic int findCh(input int idx);
        for (int i = 0; i < CH; i++) if (idx >= lo[i] && idx <= hi[i]) return i;
        return -1;
    endfunction

    task automatic modelReset();
        mQ.delete();
        mPh = P_IDLE; mCh = 0; mPrevE = 1'b0; mOvf = 1'b0; mCnt = 0; mLen = 0;
    endtask

    // Compare the current cycle against the model, advance the model, clock once.
    task automatic step();
        logic expV, pop, drop;
        int   nPh, c;
        ent_t e;
        expV = (mQ.size() > 0);
        if (done != '0) begin doneSeen++; doneOr |= done; end
        chk("memV", memV, expV);
        if (expV) begin
            chk("memA", memA, mQ[0].a);
            chk("memD", memD, mQ[0].d);
            chk("memC", memC, mQ[0].c);
        end
        chk("chE", chE, (mPh == P_LOAD || mPh == P_DRAIN) ? 64'(1 << mCh) : 64'd0);
        chk("done", done, (mPh == P_DONE) ? 64'(1 << mCh) : 64'd0);
        chk("ovf", ovf, mOvf);
        if (mPh != P_DONE) chk("len", len, mLen);
        pop  = expV && memR;
        drop = 1'b0;
        nPh  = mPh;
        case (mPh)
            P_IDLE: if (dioE && !mPrevE) begin
                c = findCh(int'(dioI));
                if (c >= 0) begin mCh = c; mCnt = 0; nPh = P_LOAD; end
                else nPh = P_SKIP;
            end
            P_SKIP: if (!dioE) nPh = P_IDLE;
            P_LOAD: begin
                if (dioW) begin
                    if (mQ.size() < DEPTH) begin
                        e.c = 2'(mCh); e.a = AW'(dioA + base[mCh]); e.d = dioD;
                        mQ.push_back(e);
                        mCnt++;
                    end else drop = 1'b1;
                end
                if (!dioE) nPh = P_DRAIN;
            end
            P_DRAIN: begin
                if (dioW) drop = 1'b1;
                if (mQ.size() == 0 || (mQ.size() == 1 && memR)) begin
                    nPh = P_DONE; mLen = mCnt;
                end
            end
            default: begin
                if (dioW) drop = 1'b1;
                nPh = P_IDLE;
            end
        endcase
        if (pop) void'(mQ.pop_front());
        if (drop) mOvf = 1'b1; else if (ovfClr) mOvf = 1'b0;
        mPrevE = dioE;
        mPh    = nPh;
        @(posedge clock);
        #1;
    endtask

    // Download scenario table: rMode 0=ready always, 1=ready 1-in-4, 2=random;
    // wMode 0=strobe every cycle, 1=random strobes; -1 means "model only".
    typedef struct {
        int idx; int n; logic [AW-1:0] a0; int rMode; int wMode;
        int expCh; int expLen; int expOvf;
    } scen_t;

    task automatic runDownload(input scen_t s, input int id);
        int c;
        doneSeen = 0; doneOr = '0;
        ovfClr = 1'b1; dioE = 1'b0; dioW = 1'b0; memR = 1'b1; step();
        ovfClr = 1'b0; dioI = IW'(s.idx); dioE = 1'b1; step();
        for (int k = 0; k < s.n; k++) begin
            dioW   = (s.wMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            dioA   = s.a0 + AW'(k);
            dioD   = 8'($urandom);
            memR   = (s.rMode == 0) ? 1'b1 : (s.rMode == 1) ? (k % 4 == 0) : 1'($urandom_range(0, 1));
            ovfClr = (s.rMode == 2) && ($urandom_range(0, 7) == 0);
            step();
        end
        dioE = 1'b0; dioW = 1'b0; ovfClr = 1'b0;
        for (c = 0; c < 300; c++) begin
            memR = (s.rMode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            dioW = (s.wMode == 1) && ($urandom_range(0, 5) == 0);
            step();
            if (mPh == P_IDLE) break;
        end
        if (c == 300) chk("drainTimeout", 64'(c), 64'd0);
        dioW = 1'b0; memR = 1'b1;
        step(); step();
        if (s.expLen >= 0) chk("tblLen", len, 64'(s.expLen));
        if (s.expOvf >= 0) chk("tblOvf", ovf, 64'(s.expOvf));
        if (s.wMode == 0) chk("tblDoneCount", 64'(doneSeen), (s.expCh >= 0) ? 64'd1 : 64'd0);
        chk("tblDoneMask", doneOr, (s.expCh >= 0) ? 64'(1 << s.expCh) : 64'd0);
        $display("xfer %0d idx=%0d bytes=%0d len=%0d ovf=%0b dones=%0d", id, s.idx, s.n, len, ovf, doneSeen);
    endtask

    scen_t tbl [5];
    scen_t rs;

    initial begin
        tbl[0] = '{1, 16, 27'h0000000, 0, 0, 0, 16, 0};
        tbl[1] = '{2, 64, 27'h0000040, 1, 0, 2, 23, 1};
        tbl[2] = '{9, 10, 27'h0000000, 0, 0, -1, 23, 0};
        tbl[3] = '{3, 12, 27'h7FFFFFA, 2, 1, 3, -1, -1};
        tbl[4] = '{0, 20, 27'h0001234, 2, 1, 0, -1, -1};

        modelReset();
        repeat (3) @(posedge clock);
        #1;
        chk("rstMemV", memV, 0); chk("rstChE", chE, 0); chk("rstDone", done, 0);
        chk("rstLen", len, 0);   chk("rstOvf", ovf, 0); chk("rstMemA", memA, 0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 5; i++) runDownload(tbl[i], i);

        // Drain with ready held low: chE held, done one cycle after last transfer.
        ovfClr = 1'b1; step(); ovfClr = 1'b0;
        dioI = 8'd2; dioE = 1'b1; memR = 1'b0; step();
        for (int k = 0; k < 3; k++) begin
            dioW = 1'b1; dioA = AW'(k); dioD = 8'(8'hA0 + k); step();
        end
        dioW = 1'b0; dioE = 1'b0;
        for (int k = 0; k < 20; k++) begin chk("drainChE", chE, 4'b0100); step(); end
        memR = 1'b1;
        step(); step(); step();
        chk("drainDone", done, 4'b0100);
        step();
        chk("drainDoneOff", done, 4'b0000);
        chk("drainLen", len, 3);
        $display("xfer drain idx=2 bytes=3 len=%0d", len);

        // Index changes mid-load: every byte keeps channel 3.
        dioI = 8'd3; dioE = 1'b1; step();
        for (int k = 0; k < 8; k++) begin
            if (k == 3) dioI = 8'd0;
            dioW = 1'b1; dioA = AW'(16 + k); dioD = 8'($urandom);
            if (memV) chk("tagC", memC, 3);
            step();
        end
        dioW = 1'b0; dioE = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (memV) chk("tagC", memC, 3);
            step();
        end
        chk("tagLen", len, 8);
        $display("xfer idxchg idx=3->0 bytes=8 len=%0d", len);

        // Reset with five entries queued in LOAD.
        dioI = 8'd1; dioE = 1'b1; memR = 1'b0; step();
        for (int k = 0; k < 5; k++) begin
            dioW = 1'b1; dioA = AW'(k); dioD = 8'(k + 1); step();
        end
        dioW = 1'b0; dioE = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midRstMemV", memV, 0); chk("midRstChE", chE, 0); chk("midRstDone", done, 0);
        chk("midRstLen", len, 0);   chk("midRstOvf", ovf, 0); chk("midRstMemA", memA, 0);
        chk("midRstMemD", memD, 0); chk("midRstMemC", memC, 0);
        @(posedge clock); #1;
        reset = 1'b1; modelReset(); memR = 1'b1;
        doneSeen = 0;
        repeat (6) step();
        chk("postRstDone", 64'(doneSeen), 0);
        $display("xfer reset mid-load memV=%0b", memV);

        // Randomised downloads, including unmatched index 4.
        for (int i = 0; i < 6; i++) begin
            rs = '{int'($urandom_range(0, 4)), int'($urandom_range(1, 20)),
                   AW'($urandom), 2, 1, -1, -1, -1};
            rs.expCh = findCh(rs.idx);
            runDownload(rs, 5 + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/dio_router.md
Name: dio_router

Overview:
- Generalised download router that sits between the data_io download stream and the core's memory write port.
- Maps the download index onto one of CHANNELS targets, each defined by an index range and a base address. ROM, DCK and TZX are examples of such targets.
- Buffers the bytes in a small FIFO behind a ready/valid memory handshake, so a slow memory (SDRAM arbiter) can accept them at its own pace.
- Reports each finished load with a per-channel done pulse, a byte count and a sticky overflow flag.

Parameters:
- CHANNELS, 4, number of download targets (1..8).
- IDXW, 8, width of the download index.
- AW, 27, download and memory address width.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CH_LO, {8'd3,8'd2,8'd1,8'd0}, packed IDXW*CHANNELS vector; lowest index matched by each channel.
- CH_HI, {8'd3,8'd2,8'd1,8'd1}, packed IDXW*CHANNELS vector; highest index matched by each channel (inclusive).
- CH_BASE, 0, packed AW*CHANNELS vector; base address added to the download address for each channel.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- dioE  in  1  download active.
- dioI  in  IDXW  download index.
- dioA  in  AW  download byte address.
- dioD  in  8  download byte.
- dioW  in  1  download byte strobe, one clock wide.
- chE  out  CHANNELS  one-hot; the channel currently loading.
- memV  out  1  memory write valid.
- memR  in  1  memory ready.
- memA  out  AW  memory write address.
- memD  out  8  memory write data.
- memC  out  $clog2(CHANNELS) (minimum 1)  channel tag of the current write.
- done  out  CHANNELS  one-clock pulse when a channel's load completes.
- len  out  32  bytes accepted in the last completed load.
- ovf  out  1  sticky flag: at least one byte was dropped.
- ovfClr  in  1  clears ovf.

Behaviour:
- Reset (asynchronous, reset=0): FSM in IDLE, FIFO empty. Outputs: chE=0, memV=0, memA=0, memD=0, memC=0, done=0, len=0, ovf=0. Reset mid-load discards FIFO contents; no done pulse is generated.
- Channel match: dioI is matched against [CH_LO[i], CH_HI[i]]. The lowest i that matches wins. If no channel matches, the download is ignored.
- FSM states and transitions:
  - IDLE: on rising edge of dioE with a match, latch ch and clear cnt, then go to LOAD. With no match, go to SKIP.
  - SKIP: all strobes ignored; return to IDLE when dioE=0.
  - LOAD: chE[ch]=1. Each dioW is a push. On dioE=0, go to DRAIN.
  - DRAIN: chE held. Go to DONE once the FIFO is empty and no write is outstanding.
  - DONE: one cycle; done[ch]=1, len<=cnt, chE released; then IDLE.
- dioI is sampled only at the IDLE→LOAD transition; index changes mid-load are ignored.
- A rising dioE during DRAIN or DONE is not seen as a new load. Any dioW strobes in those states are dropped and set ovf.
- Push rule:
  - In LOAD, dioW with FIFO not full writes the entry {ch, dioA+CH_BASE[ch] modulo 2^AW, dioD} and increments cnt (32-bit, wraps).
  - dioW with FIFO full drops the byte, sets ovf, and leaves cnt unchanged. This holds even if a pop occurs in the same cycle.
- Pop/handshake rule:
  - memV=1 whenever the FIFO is non-empty; memA, memD and memC show the head entry.
  - A transfer happens on memV && memR; the head advances in that cycle.
  - memV must not drop, and memA/memD/memC must not change, until the transfer is accepted.
- Latency: a byte pushed at cycle n appears on memV/memA/memD at n+1 when the FIFO was empty.
- Full throughput: with memR held at 1, one byte per clock.
- Simultaneous push and pop on a non-empty, non-full FIFO: both take effect; occupancy is unchanged.
- Empty: occupancy 0 with no pop. Full: occupancy DEPTH. Read and write pointers are log2(DEPTH)+1 bits wide so full and empty can be told apart.
- ovf is set by any dropped byte and cleared by ovfClr. If both happen in the same cycle, set wins.

Decomposition:
- Shared package dio_pkg: state encoding (IDLE, SKIP, LOAD, DRAIN, DONE) and a function computing the channel index width.
- One sub-module: dio_fifo, a synchronous DEPTH x (AW+8+CW) FIFO with full and empty outputs, reused elsewhere.

Test Plan:
- Index 1 download, addresses 0..15, CH_BASE[0]=0x100000, memR=1 → memA 0x100000..0x10000F in order; chE=0001; done[0] pulse; len=16; ovf=0.
- Index 2, 64 bytes at one per clock, memR toggled 1-in-4 (DEPTH=8) → ovf=1; len = bytes accepted; memory receives exactly len bytes in order; memV stable while memR=0.
- Index 9 (no match), 10 strobes → memV never asserted, chE=0, no done, len unchanged.
- Reset asserted with 5 entries queued in LOAD → all outputs 0 immediately; after release memV=0 and no done pulse.
- dioE falls while 3 entries are pending, memR=0 for 20 cycles, then 1 → chE held during DRAIN; done[ch] fires exactly one cycle after the last transfer.
- Index changes from 3 to 0 mid-load → all bytes tagged memC=3 with the TZX base.
